pingpong_line_buffer_ctrl: RTL
==============================

// Module: pingpong_line_buffer_ctrl
// PURPOSE
//  Write-side scheduler between the HSYNC-framed pixel source and the SPIHT
//  wavelet core. It packs incoming lines into one of two RAM banks, BANK_LINES
//  lines per bank. It hands each full bank to the core with a ready/ack
//  handshake, then ping-pongs to the other bank.
//  It flags overflow when both banks are held by the core, and flags malformed lines.
// PARAMETERS
//  IMG_WIDTH   512  pixels per line; one line = one HSYNC-high run
//  IMG_HEIGHT  512  lines per frame; must be a multiple of BANK_LINES
//  BANK_LINES  16   lines per bank
//  DATA_W      16   pixel width
//  ADDR_W      13   bank address width; 2**ADDR_W >= IMG_WIDTH*BANK_LINES
// PORTS
//  PCLK        in   1       pixel clock; all logic on its rising edge
//  RST         in   1       synchronous reset, active-high
//  HSYNC       in   1       high while Pixel_DATA carries a valid pixel
//  Pixel_DATA  in   DATA_W  pixel sample, valid when HSYNC=1
//  BANK_ACK    in   2       1-cycle pulse per bank: core has consumed bank[i]
//  WR_EN       out  1       bank RAM write strobe
//  WR_BANK     out  1       bank select for the write
//  WR_ADDR     out  ADDR_W  address within the bank
//  WR_DATA     out  DATA_W  registered pixel
//  BANK_RDY    out  2       level; bank[i] holds data owned by the core
//  FRAME_END   out  1       1-cycle pulse after the last line of a frame
//  OVERFLOW    out  1       sticky; at least one line was dropped
//  LINE_ERR    out  1       sticky; a line was not exactly IMG_WIDTH pixels long
// BEHAVIOUR
//  Reset: all outputs 0; counters 0; active bank 0; state S_SYNC.
//   Reset has priority over every other event; mid-line reset discards that line.
//  Line edges: HSYNC_d is HSYNC registered.
//   Line start: HSYNC=1 and HSYNC_d=0. Line end: HSYNC=0 and HSYNC_d=1.
//  FSM:
//   S_SYNC: ignore input. Go to S_FILL at the first line start.
//    That start cycle counts as pixel 0 of line 0.
//   S_FILL: for each HSYNC=1 cycle with col<IMG_WIDTH:
//    - WR_EN=1, WR_BANK=active, WR_DATA=Pixel_DATA.
//    - WR_ADDR=bank_line*IMG_WIDTH+col, from a running counter with no multiplier.
//    - Latency is 1 cycle from input to WR_*.
//   S_WAIT: the next bank is still BANK_RDY. Whole lines are dropped (WR_EN=0)
//    and OVERFLOW is set at each dropped line start. Go to S_FILL at the first
//    line start seen with the next bank free.
//  Column counter col: cleared at line end.
//   Pixels with col>=IMG_WIDTH are not written and set LINE_ERR.
//   At line end, col<IMG_WIDTH sets LINE_ERR; the line still counts as complete.
//  At each line end, frame_line increments, whether the line was written or dropped.
//   In S_FILL, bank_line also increments.
//  Bank complete (bank_line==BANK_LINES, or frame end with bank_line>0):
//   - Set BANK_RDY[active], toggle active, clear bank_line.
//   - If BANK_RDY[new active] is already 1, go to S_WAIT.
//  Frame end (frame_line==IMG_HEIGHT): FRAME_END pulses on the cycle after
//   the line end, frame_line clears, and the FSM stays in S_FILL or S_WAIT.
//  BANK_ACK[i] clears BANK_RDY[i] on the next edge.
//   An ACK for a bank with BANK_RDY=0 is ignored.
//   An ACK and a completion of the same bank in one cycle: the completion wins.
//   An ACK and a line start in one cycle: the ACK is evaluated first, so the
//    line is accepted.
//  HSYNC glitch (a 1-cycle high) is a 1-pixel line: it writes one pixel, sets
//   LINE_ERR, and advances the line counters.
// TESTING
//  T1 reset, then 16 clean 512-px lines -> 8192 writes to bank 0 at addr 0..8191,
//   BANK_RDY=01, active=1, flags 0.
//  T2 no BANK_ACK while 48 lines arrive -> bank 1 fills and BANK_RDY=11; lines
//   33..48 are dropped with WR_EN=0; OVERFLOW=1.
//  T3 BANK_ACK[0] on the same cycle as a line start while in S_WAIT -> that line
//   is written to bank 0 at addr 0..511.
//  T4 one 500-px line and one 520-px line -> LINE_ERR=1; the 520-px line's last
//   8 pixels are not written; the next line starts at addr bank_line*512.
//  T5 full 512-line frame with prompt ACKs -> 32 bank handoffs alternating 0/1;
//   one FRAME_END pulse one cycle after the last line end.
//  T6 RST asserted at pixel 200 of a line -> outputs 0 next edge; the rest of that
//   line is ignored; the next line is written at bank 0 addr 0.

Source files
------------

// File: rtl/pingpong_line_buffer_ctrl.sv
// Write-side ping-pong scheduler: packs HSYNC-framed lines into two RAM banks,
// hands each full bank to the wavelet core via BANK_RDY/BANK_ACK, flags drops and bad lines.
module pingpong_line_buffer_ctrl #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int BANK_LINES = 16,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              HSYNC,
  input  logic [DATA_W-1:0] Pixel_DATA,
  input  logic [1:0]        BANK_ACK,
  output logic              WR_EN,
  output logic              WR_BANK,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [1:0]        BANK_RDY,
  output logic              FRAME_END,
  output logic              OVERFLOW,
  output logic              LINE_ERR
);

  localparam int COL_W = $clog2(IMG_WIDTH + 1);
  localparam int BL_W  = $clog2(BANK_LINES + 1);
  localparam int FL_W  = $clog2(IMG_HEIGHT + 1);

  typedef enum logic [1:0] {S_SYNC, S_FILL, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic              hsync_d;
  logic [COL_W-1:0]  col;
  logic [BL_W-1:0]   bank_line;
  logic [FL_W-1:0]   frame_line;
  logic [ADDR_W-1:0] line_base;
  logic              active;

  logic       line_start, line_end, counting, col_ok;
  logic       accept, wr_now, drop_start, frame_done, fill_end, bank_done, len_err;
  logic [1:0] rdy_eff, rdy_nxt;

  // NOTE: hsync_d is deliberately left out of reset so that a line in flight
  // across reset is not mistaken for a fresh line start once reset releases.
  always_ff @(posedge PCLK) begin
    hsync_d <= HSYNC;
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (RST) state <= S_SYNC;
    else     state <= state_nxt;
  end

  // Event decode; an ACK this cycle already frees its bank for the decisions below
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rdy_nxt    = '0;
    line_start = HSYNC & ~hsync_d;
    line_end   = ~HSYNC & hsync_d;
    rdy_eff    = BANK_RDY & ~BANK_ACK;
    counting   = (state != S_SYNC);
    col_ok     = (col < COL_W'(IMG_WIDTH));
    accept     = line_start && ((state == S_SYNC) ||
                                ((state == S_WAIT) && !rdy_eff[active]));
    wr_now     = HSYNC && col_ok && ((state == S_FILL) || accept);
    drop_start = (state == S_WAIT) && line_start && rdy_eff[active];
    frame_done = counting && line_end && (frame_line == FL_W'(IMG_HEIGHT - 1));
    fill_end   = (state == S_FILL) && line_end;
    bank_done  = fill_end && ((bank_line == BL_W'(BANK_LINES - 1)) || frame_done);
    len_err    = counting && ((HSYNC && !col_ok) || (line_end && col_ok));
    rdy_nxt    = rdy_eff;
    if (bank_done) rdy_nxt[active] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_SYNC:  if (line_start) state_nxt = S_FILL;
      S_FILL:  if (bank_done && rdy_eff[~active]) state_nxt = S_WAIT;
      S_WAIT:  if (accept) state_nxt = S_FILL;
      default: state_nxt = S_SYNC;
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge PCLK) begin
    if (RST) begin
      col        <= '0;
      bank_line  <= '0;
      frame_line <= '0;
      line_base  <= '0;
      active     <= 1'b0;
      BANK_RDY   <= '0;
      WR_EN      <= 1'b0;
      WR_BANK    <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      FRAME_END  <= 1'b0;
      OVERFLOW   <= 1'b0;
      LINE_ERR   <= 1'b0;
    end else begin
      // col saturates at IMG_WIDTH so over-long lines cannot wrap into valid addresses
      if (line_end)                               col <= '0;
      else if (HSYNC && col != COL_W'(IMG_WIDTH)) col <= col + 1'b1;

      if (counting && line_end)
        frame_line <= frame_done ? '0 : frame_line + 1'b1;

      if (bank_done) begin
        bank_line <= '0;
        line_base <= '0;
        active    <= ~active;
      end else if (fill_end) begin
        bank_line <= bank_line + 1'b1;
        line_base <= line_base + ADDR_W'(IMG_WIDTH);
      end

      BANK_RDY <= rdy_nxt;
      WR_EN    <= wr_now;
      if (wr_now) begin
        WR_BANK <= active;
        WR_ADDR <= line_base + ADDR_W'(col);
        WR_DATA <= Pixel_DATA;
      end
      FRAME_END <= frame_done;
      OVERFLOW  <= OVERFLOW | drop_start;
      LINE_ERR  <= LINE_ERR | len_err;
    end
  end

endmodule
